// File: rtl/elevator_shaft_model.sv
// Car/shaft/door plant closing the loop around elevator_controller: absolute car position,
// four-state door FSM and sticky illegal-command flags. Define SHAFT_LOAD_SENSE_EN for load sensing.
module elevator_shaft_model #(
  parameter int N             = 8,
  parameter int TRAVEL_CYCLES = 16,
  parameter int DOOR_CYCLES   = 4,
  parameter int LOAD_LIMIT    = 200
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 motor_up,
  input  logic                 motor_down,
  input  logic                 open_door,
  input  logic                 close_door,
  input  logic [7:0]           load,
  output logic [N-1:0]         floor_sensor,
  output logic [$clog2(N)-1:0] car_floor,
  output logic                 door_closed,
  output logic                 door_open,
  output logic                 overweight_sensor,
  output logic [3:0]           fault
);

  localparam int FW      = $clog2(N);
  localparam int LOG_T   = $clog2(TRAVEL_CYCLES);
  localparam int POS_MAX = (N - 1) * TRAVEL_CYCLES;
  localparam int PW      = $clog2(POS_MAX + 1);
  localparam int CW      = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
  localparam logic [CW-1:0] STROKE = CW'(DOOR_CYCLES - 1);

  typedef enum logic [1:0] {CLOSED, OPENING, OPEN, CLOSING} door_state_t;

  door_state_t   door_state, door_next;
  logic [CW-1:0] cnt, cnt_next;
  logic [PW-1:0] pos, pos_next;
  logic          aligned, at_top, at_bot, one_motor, door_idle, open_fault;
  logic [3:0]    fault_set;

  // Single-step move clamped to the shaft ends.
  function automatic logic [PW-1:0] sat_step(input logic [PW-1:0] p, input logic up,
                                             input logic down);
    sat_step = p;
    if (up && p != PW'(POS_MAX))
      sat_step = p + 1'b1;
    else if (down && p != '0)
      sat_step = p - 1'b1;
  endfunction

  assign aligned      = (pos[LOG_T-1:0] == '0);
  assign car_floor    = FW'(pos >> LOG_T);
  assign floor_sensor = aligned ? (N'(1) << car_floor) : '0;
  assign door_closed  = (door_state == CLOSED);
  assign door_open    = (door_state == OPEN);

  assign at_top    = (pos == PW'(POS_MAX));
  assign at_bot    = (pos == '0);
  assign one_motor = motor_up ^ motor_down;
  assign door_idle = (door_state == CLOSED);
  assign pos_next  = (one_motor && door_idle) ? sat_step(pos, motor_up, motor_down) : pos;

  assign fault_set[0] = motor_up & motor_down;
  assign fault_set[1] = (motor_up | motor_down) & ~door_idle;
  assign fault_set[2] = one_motor & ((motor_up & at_top) | (motor_down & at_bot));
  assign fault_set[3] = open_fault;

  always_comb begin
    door_next  = door_state;
    cnt_next   = cnt;
    open_fault = 1'b0;
    unique case (door_state)
      CLOSED: begin
        if (open_door) begin
          if (aligned) begin
            door_next = OPENING;
            cnt_next  = STROKE;
          end else begin
            open_fault = 1'b1;
          end
        end
      end
      OPENING: begin
        // A simultaneous open request matches the target, so it overrides close.
        if (close_door && !open_door) begin
          door_next = CLOSING;
          cnt_next  = STROKE;
        end else if (cnt == '0) begin
          door_next = OPEN;
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      OPEN: begin
        if (close_door && !open_door) begin
          door_next = CLOSING;
          cnt_next  = STROKE;
        end
      end
      CLOSING: begin
        if (open_door) begin
          door_next = OPENING;
          cnt_next  = STROKE;
        end else if (cnt == '0) begin
          door_next = CLOSED;
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      default: door_next = CLOSED;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      door_state <= CLOSED;
      cnt        <= '0;
      pos        <= '0;
      fault      <= '0;
    end else begin
      door_state <= door_next;
      cnt        <= cnt_next;
      pos        <= pos_next;
      fault      <= fault | fault_set;
    end
  end

`ifdef SHAFT_LOAD_SENSE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      overweight_sensor <= 1'b0;
    else
      overweight_sensor <= (load > LOAD_LIMIT[7:0]) && !door_closed;
  end
`else
  logic unused_load;
  assign unused_load       = (^load) ^ (LOAD_LIMIT != 0);
  assign overweight_sensor = 1'b0;
`endif

endmodule

// File: tb/tb_elevator_shaft_model.sv
// Directed bench for elevator_shaft_model (N=8, T=16, door stroke 4); expectations follow the
// SHAFT_LOAD_SENSE_EN define of the build.
module tb_elevator_shaft_model;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       motor_up, motor_down, open_door, close_door;
  logic [7:0] load;
  logic [7:0] floor_sensor;
  logic [2:0] car_floor;
  logic       door_closed, door_open, overweight_sensor;
  logic [3:0] fault;
  int         checks = 0;
  int         errors = 0;

`ifdef SHAFT_LOAD_SENSE_EN
  localparam logic OW_EXP = 1'b1;
`else
  localparam logic OW_EXP = 1'b0;
`endif

  elevator_shaft_model #(
    .N(8), .TRAVEL_CYCLES(16), .DOOR_CYCLES(4), .LOAD_LIMIT(200)
  ) dut (
    .clk(clk), .rst_n(rst_n), .motor_up(motor_up), .motor_down(motor_down),
    .open_door(open_door), .close_door(close_door), .load(load),
    .floor_sensor(floor_sensor), .car_floor(car_floor), .door_closed(door_closed),
    .door_open(door_open), .overweight_sensor(overweight_sensor), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; motor_up = 1'b0; motor_down = 1'b0;
    open_door = 1'b0; close_door = 1'b0; load = 8'd0;
    tick(3);
    chk("rst_fs", 32'(floor_sensor), 32'h01);
    chk("rst_door", 32'({door_closed, door_open}), 32'b10);
    rst_n = 1'b1;

    // T1 idle
    tick(10);
    chk("t1_fs", 32'(floor_sensor), 32'h01);
    chk("t1_door_closed", 32'(door_closed), 32'h1);
    chk("t1_fault", 32'(fault), 32'h0);
    chk("t1_ow", 32'(overweight_sensor), 32'h0);

    // T2 climb two floors
    motor_up = 1'b1;
    tick(1);  chk("t2_fs_c1", 32'(floor_sensor), 32'h00);
    tick(14); chk("t2_fs_c15", 32'(floor_sensor), 32'h00);
    tick(1);  chk("t2_fs_c16", 32'(floor_sensor), 32'h02);
    chk("t2_cf_c16", 32'(car_floor), 32'd1);
    tick(1);  chk("t2_fs_c17", 32'(floor_sensor), 32'h00);
    tick(15); chk("t2_fs_c32", 32'(floor_sensor), 32'h04);
    chk("t2_cf_c32", 32'(car_floor), 32'd2);
    motor_up = 1'b0;
    tick(2);  chk("t2_hold", 32'(floor_sensor), 32'h04);

    // T3 door stroke and reversal
    open_door = 1'b1; tick(1); open_door = 1'b0;
    chk("t3_opening", 32'({door_closed, door_open}), 32'b00);
    tick(3);  chk("t3_not_yet", 32'(door_open), 32'h0);
    tick(1);  chk("t3_open", 32'(door_open), 32'h1);
    close_door = 1'b1; tick(1); close_door = 1'b0;
    chk("t3_closing", 32'({door_closed, door_open}), 32'b00);
    tick(1);
    open_door = 1'b1; tick(1); open_door = 1'b0;
    chk("t3_reverse_closed", 32'(door_closed), 32'h0);
    tick(3);  chk("t3_rev_not_open", 32'({door_closed, door_open}), 32'b00);
    tick(1);  chk("t3_reopened", 32'(door_open), 32'h1);
    open_door = 1'b1; close_door = 1'b1; tick(1);
    open_door = 1'b0; close_door = 1'b0;
    chk("t3_open_wins", 32'(door_open), 32'h1);

    // T4 illegal commands
    close_door = 1'b1; tick(1); close_door = 1'b0;
    tick(4);  chk("t4_closed", 32'(door_closed), 32'h1);
    motor_up = 1'b1; motor_down = 1'b1; tick(1);
    motor_up = 1'b0; motor_down = 1'b0;
    chk("t4_both_fault", 32'(fault), 32'b0001);
    chk("t4_both_pos", 32'(floor_sensor), 32'h04);
    open_door = 1'b1; tick(1); open_door = 1'b0;
    tick(4);  chk("t4_open", 32'(door_open), 32'h1);
    motor_up = 1'b1; tick(1); motor_up = 1'b0;
    chk("t4_door_fault", 32'(fault), 32'b0011);
    chk("t4_door_pos", 32'(floor_sensor), 32'h04);
    close_door = 1'b1; tick(1); close_door = 1'b0;
    tick(4);
    motor_down = 1'b1; tick(32);
    chk("t4_floor0", 32'(floor_sensor), 32'h01);
    chk("t4_floor0_fault", 32'(fault), 32'b0011);
    tick(1); motor_down = 1'b0;
    chk("t4_under_fault", 32'(fault), 32'b0111);
    chk("t4_under_pos", 32'(floor_sensor), 32'h01);

    // T5 mid-shaft stop, misaligned open, async reset
    motor_up = 1'b1; tick(8); motor_up = 1'b0;
    chk("t5_mid_fs", 32'(floor_sensor), 32'h00);
    tick(3);  chk("t5_no_drift", 32'({car_floor, floor_sensor}), 32'h000);
    open_door = 1'b1; tick(1); open_door = 1'b0;
    tick(2);
    chk("t5_door_stays", 32'(door_closed), 32'h1);
    chk("t5_fault", 32'(fault), 32'b1111);
    rst_n = 1'b0; #1;
    chk("t5_async_fs", 32'(floor_sensor), 32'h01);
    chk("t5_async_fault", 32'(fault), 32'h0);
    tick(2); rst_n = 1'b1;
    tick(1);  chk("t5_after_rst", 32'(floor_sensor), 32'h01);

    // top overtravel
    motor_up = 1'b1; tick(112);
    chk("top_fs", 32'(floor_sensor), 32'h80);
    chk("top_cf", 32'(car_floor), 32'd7);
    chk("top_fault0", 32'(fault), 32'h0);
    tick(1); motor_up = 1'b0;
    chk("top_over_fault", 32'(fault), 32'b0100);
    chk("top_over_fs", 32'(floor_sensor), 32'h80);

    // T6 load sensing
    load = 8'd201; tick(1);
    chk("t6_closed_ow", 32'(overweight_sensor), 32'h0);
    open_door = 1'b1; tick(1); open_door = 1'b0;
    tick(4);  chk("t6_open", 32'(door_open), 32'h1);
    tick(1);  chk("t6_ow_201", 32'(overweight_sensor), 32'(OW_EXP));
    load = 8'd200; tick(1);
    chk("t6_ow_200", 32'(overweight_sensor), 32'h0);
    load = 8'd201; tick(1);
    chk("t6_ow_201b", 32'(overweight_sensor), 32'(OW_EXP));
    close_door = 1'b1; tick(1); close_door = 1'b0;
    tick(4);
    chk("t6_closed", 32'(door_closed), 32'h1);
    chk("t6_ow_lag", 32'(overweight_sensor), 32'(OW_EXP));
    tick(1);  chk("t6_ow_cleared", 32'(overweight_sensor), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
